// File: rtl/stage_sync_sink.sv
// stage_sync_sink: clocked receiver for the bundled-data req/ack async pipeline.
// Synchronizes req_in, runs a 4-phase return-to-zero handshake and buffers the
// captured words in a small FIFO that is read through a valid/ready port.
// Optional feature macro: SINK_SEQ_CHECK_EN (enables the sticky sequence checker
// on seq_err; when undefined seq_err is tied low).
module stage_sync_sink #(
    parameter int unsigned DW          = 3,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_in,
    input  logic [DW-1:0]            data_in,
    output logic                     ack_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     seq_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAPT = 2'd1,
        S_ACKH = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_req_sync;
    logic                    w_req_s;
    logic                    r_ack;
    logic                    w_wr_en;
    logic                    w_full;
    logic                    w_pop;

    logic [DW-1:0]           r_mem [DEPTH];
    logic [AW-1:0]           r_wptr;
    logic [AW-1:0]           r_rptr;
    logic [AW-1:0]           w_rptr_nxt;
    logic [CW-1:0]           r_count;
    logic [CW-1:0]           w_count_nxt;
    logic                    r_out_valid;
    logic [DW-1:0]           r_out_data;

    assign w_req_s   = r_req_sync[SYNC_STAGES-1];
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = r_out_valid & out_ready;

    assign ack_out   = r_ack;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign count     = r_count;

    // Request synchronizer: shift req_in through SYNC_STAGES flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_sync <= '0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], req_in};
        end
    end

    // Handshake state register and registered acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= (w_state_nxt == S_ACKH);
        end
    end

    // Next-state logic; FIFO write strobe asserted only in CAPT (ack still low).
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Registered count decides: a same-cycle pop does not unblock.
                if (w_req_s && !w_full) begin
                    w_state_nxt = S_CAPT;
                end
            end
            S_CAPT: begin
                w_wr_en     = 1'b1;
                w_state_nxt = S_ACKH;
            end
            S_ACKH: begin
                if (!w_req_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FIFO next read pointer and occupancy.
    always_comb begin
        w_rptr_nxt  = w_pop ? (r_rptr + AW'(1)) : r_rptr;
        w_count_nxt = r_count;
        if (w_wr_en && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_wr_en && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // FIFO storage: written at the tail during CAPT.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= data_in;
        end
    end

    // FIFO pointers, occupancy and registered head word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + AW'(1);
            end
            r_rptr      <= w_rptr_nxt;
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);
            // Head register preloads the next head; the word being written this
            // cycle bypasses memory when it becomes the head. Holds when empty.
            if (w_count_nxt != '0) begin
                if (w_wr_en && (r_wptr == w_rptr_nxt)) begin
                    r_out_data <= data_in;
                end else begin
                    r_out_data <= r_mem[w_rptr_nxt];
                end
            end
        end
    end

`ifdef SINK_SEQ_CHECK_EN
    logic [DW-1:0] r_exp;
    logic          r_exp_valid;
    logic          r_seq_err;

    assign seq_err = r_seq_err;

    // Sequence checker: each capture must equal previous capture + 1 (mod 2^DW).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exp       <= '0;
            r_exp_valid <= 1'b0;
            r_seq_err   <= 1'b0;
        end else if (w_wr_en) begin
            if (r_exp_valid && (data_in != r_exp)) begin
                r_seq_err <= 1'b1;
            end
            r_exp       <= data_in + DW'(1);
            r_exp_valid <= 1'b1;
        end
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_stage_sync_sink.sv
// Directed testbench for stage_sync_sink: handshake latency, FIFO fill and
// backpressure, streaming order, mid-handshake reset and the sequence checker.
module tb_stage_sync_sink;

    localparam int unsigned DW    = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

`ifdef SINK_SEQ_CHECK_EN
    localparam logic SEQ_ON = 1'b1;
`else
    localparam logic SEQ_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          req_in;
    logic [DW-1:0] data_in;
    logic          ack_out;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;
    logic          seq_err;

    int n_tests;
    int n_fail;

    logic          mon_en;
    logic [DW-1:0] got[$];
    int            max_cnt;

    stage_sync_sink #(
        .DW(DW),
        .DEPTH(DEPTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_in(req_in),
        .data_in(data_in),
        .ack_out(ack_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .count(count),
        .seq_err(seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop monitor: records each word accepted by the consumer.
    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (out_valid && out_ready) got.push_back(out_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; req_in = 1'b0; out_ready = 1'b0; data_in = '0;
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    // One full 4-phase transaction; returns clocks to ack rise / ack fall (-1 on timeout).
    task automatic send_word(input logic [DW-1:0] d, output int up, output int dn);
        data_in = d; req_in = 1'b1; up = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ack_out) begin up = i; break; end
        end
        req_in = 1'b0; dn = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (!ack_out) begin dn = i; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_in = 1'b1; out_ready = 1'b0; data_in = 3'd7;
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (ack_out !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", ack_out); end
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
            n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %0d exp 0", out_data); end
        n_tests++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_seqerr got %b exp 0", seq_err); end
        req_in = 1'b0;
        rst = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic test_single_word();
        int up, dn;
        apply_reset();
        send_word(3'b101, up, dn);
        n_tests++; if (up !== 4) begin n_fail++; $display("FAIL single_ack_rise got %0d exp 4", up); end
        n_tests++; if (dn !== 3) begin n_fail++; $display("FAIL single_ack_fall got %0d exp 3", dn); end
        n_tests++; if (out_data !== 3'd5) begin n_fail++; $display("FAIL single_data got %0d exp 5", out_data); end
        n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", count); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", out_valid); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_pop_count got %0d exp 0", count); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid got %b exp 0", out_valid); end
        n_tests++; if (out_data !== 3'd5) begin n_fail++; $display("FAIL single_hold_data got %0d exp 5", out_data); end
    endtask

    task automatic test_fill_backpressure();
        int up, dn;
        logic held_hi;
        logic [DW-1:0] exp_q [4];
        exp_q[0] = 3'd2; exp_q[1] = 3'd3; exp_q[2] = 3'd4; exp_q[3] = 3'd5;
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            send_word(DW'(i), up, dn);
            n_tests++; if (up !== 4) begin n_fail++; $display("FAIL fill_ack_rise word %0d got %0d exp 4", i, up); end
        end
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d exp 4", count); end
        n_tests++; if (out_data !== 3'd1) begin n_fail++; $display("FAIL fill_head got %0d exp 1", out_data); end
        data_in = 3'd5; req_in = 1'b1; held_hi = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack_out) held_hi = 1'b1;
        end
        n_tests++; if (held_hi !== 1'b0) begin n_fail++; $display("FAIL full_ack_held got %b exp 0", held_hi); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL pop_count got %0d exp 3", count); end
        n_tests++; if (out_data !== 3'd2) begin n_fail++; $display("FAIL pop_head got %0d exp 2", out_data); end
        up = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (ack_out) begin up = i; break; end
        end
        n_tests++; if (up !== 2) begin n_fail++; $display("FAIL unblock_ack_rise got %0d exp 2", up); end
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL unblock_count got %0d exp 4", count); end
        req_in = 1'b0; dn = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (!ack_out) begin dn = i; break; end
        end
        n_tests++; if (dn !== 3) begin n_fail++; $display("FAIL unblock_ack_fall got %0d exp 3", dn); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (out_data !== exp_q[i] || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL drain_data[%0d] got %0d/v%b exp %0d/v1", i, out_data, out_valid, exp_q[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        n_tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_empty got count %0d valid %b exp 0/0", count, out_valid);
        end
        n_tests++; if (out_data !== 3'd5) begin n_fail++; $display("FAIL drain_hold got %0d exp 5", out_data); end
    endtask

    task automatic test_back_to_back();
        int up, dn;
        apply_reset();
        out_ready = 1'b1;
        got.delete(); max_cnt = 0; mon_en = 1'b1;
        for (int i = 0; i < 8; i++) send_word(DW'(i), up, dn);
        tick(); tick();
        mon_en = 1'b0; out_ready = 1'b0;
        n_tests++; if (got.size() !== 8) begin n_fail++; $display("FAIL stream_len got %0d exp 8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) begin
                n_tests++; if (got[i] !== DW'(i)) begin n_fail++; $display("FAIL stream_data[%0d] got %0d exp %0d", i, got[i], i); end
            end
        end
        n_tests++; if (max_cnt > 1) begin n_fail++; $display("FAIL stream_count got max %0d exp <=1", max_cnt); end
        n_tests++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL stream_seqerr got %b exp 0", seq_err); end
    endtask

    task automatic test_midop_reset();
        int up, dn;
        apply_reset();
        send_word(3'd3, up, dn);
        data_in = 3'd4; req_in = 1'b1; up = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ack_out) begin up = i; break; end
        end
        n_tests++; if (up !== 4 || count !== 3'd2) begin
            n_fail++; $display("FAIL midop_setup got ack_lat %0d count %0d exp 4/2", up, count);
        end
        rst = 1'b0;
        #2;
        n_tests++; if (ack_out !== 1'b0) begin n_fail++; $display("FAIL midop_ack got %b exp 0", ack_out); end
        n_tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midop_fifo got count %0d valid %b exp 0/0", count, out_valid);
        end
        req_in = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        send_word(3'd6, up, dn);
        n_tests++; if (up !== 4 || dn !== 3) begin n_fail++; $display("FAIL resume_lat got %0d/%0d exp 4/3", up, dn); end
        n_tests++; if (count !== 3'd1 || out_data !== 3'd6) begin
            n_fail++; $display("FAIL resume_fifo got count %0d data %0d exp 1/6", count, out_data);
        end
    endtask

    task automatic test_seq_check();
        int up, dn;
        apply_reset();
        out_ready = 1'b1;
        send_word(3'd2, up, dn);
        n_tests++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_w1 got %b exp 0", seq_err); end
        send_word(3'd3, up, dn);
        n_tests++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_w2 got %b exp 0", seq_err); end
        send_word(3'd5, up, dn);
        n_tests++; if (seq_err !== SEQ_ON) begin n_fail++; $display("FAIL seq_w3 got %b exp %b", seq_err, SEQ_ON); end
        send_word(3'd6, up, dn);
        n_tests++; if (seq_err !== SEQ_ON) begin n_fail++; $display("FAIL seq_sticky got %b exp %b", seq_err, SEQ_ON); end
        out_ready = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; mon_en = 1'b0; max_cnt = 0;
        rst = 1'b1; req_in = 1'b0; out_ready = 1'b0; data_in = '0;
        test_reset();
        test_single_word();
        test_fill_backpressure();
        test_back_to_back();
        test_midop_reset();
        test_seq_check();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
